video_stream_meter: RTL

Synthesizable receive-side monitor for the pixel stream (`di`/`de`/`hs`/`vs`) used around the scaler blocks. It sits on the scaler output, or any stream in the chain, and measures the geometry of every line and frame as it passes. It checks the measured geometry against expected values and reports sticky protocol errors, so hardware and simulation can both confirm scaler output dimensions without a file-writing monitor.

---
 rtl/video_stream_meter.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/video_stream_meter.sv
`default_nettype none
// ============================================================================
// Module   : video_stream_meter
// Purpose  : Measures line width / frame height of a di/de/hs/vs pixel stream,
//            checks them against expected values and raises sticky errors.
//            Optional macro VIDEO_METER_SUM_EN adds a per-frame pixel sum.
// Revision : 1.0  initial release
// ============================================================================
module video_stream_meter #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] di_i,
    input  logic                  de_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    input  logic [CNT_WIDTH-1:0]  expect_w,
    input  logic [CNT_WIDTH-1:0]  expect_h,
    input  logic                  clr,
    output logic [CNT_WIDTH-1:0]  line_width,
    output logic [CNT_WIDTH-1:0]  frame_height,
    output logic [15:0]           frame_cnt,
    output logic                  line_done,
    output logic                  frame_done,
`ifdef VIDEO_METER_SUM_EN
    output logic [31:0]           frame_sum,
`endif
    output logic                  err_width,
    output logic                  err_height,
    output logic                  err_sync
);

    localparam logic [1:0] S_SYNC   = 2'd0;
    localparam logic [1:0] S_VBLANK = 2'd1;
    localparam logic [1:0] S_HBLANK = 2'd2;
    localparam logic [1:0] S_LINE   = 2'd3;

    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};

    // Input staging plus one extra stage of hs/vs for edge detection
    logic [DATA_WIDTH-1:0] r_di;
    logic                  r_de;
    logic                  r_hs;
    logic                  r_vs;
    logic                  r_hs_d;
    logic                  r_vs_d;
    logic [CNT_WIDTH-1:0]  r_exp_w;
    logic [CNT_WIDTH-1:0]  r_exp_h;
    logic                  r_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_di    <= '0;
            r_de    <= 1'b0;
            r_hs    <= 1'b0;
            r_vs    <= 1'b0;
            r_hs_d  <= 1'b0;
            r_vs_d  <= 1'b0;
            r_exp_w <= '0;
            r_exp_h <= '0;
            r_clr   <= 1'b0;
        end else begin
            r_di    <= di_i;
            r_de    <= de_i;
            r_hs    <= hs_i;
            r_vs    <= vs_i;
            r_hs_d  <= r_hs;
            r_vs_d  <= r_vs;
            r_exp_w <= expect_w;
            r_exp_h <= expect_h;
            r_clr   <= clr;
        end
    end

    logic w_hs_rise;
    logic w_hs_fall;
    logic w_vs_rise;
    logic w_vs_fall;
    logic w_pix;

    assign w_hs_rise = r_hs & ~r_hs_d;
    assign w_hs_fall = ~r_hs & r_hs_d;
    assign w_vs_rise = r_vs & ~r_vs_d;
    assign w_vs_fall = ~r_vs & r_vs_d;
    assign w_pix     = r_de & ~r_hs & ~r_vs;

    // FSM
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_count;
    logic       w_start_line;
    logic       w_start_frame;
    logic       w_close_line;
    logic       w_close_frame;
    logic       w_set_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_count       = 1'b0;
        w_start_line  = 1'b0;
        w_start_frame = 1'b0;
        w_close_line  = 1'b0;
        w_close_frame = 1'b0;
        w_set_sync    = 1'b0;
        case (r_state)
            S_SYNC: begin
                if (r_vs) begin
                    w_state_nxt = S_VBLANK;
                end
            end
            S_VBLANK: begin
                if (w_vs_fall) begin
                    w_start_frame = 1'b1;
                    w_state_nxt   = S_HBLANK;
                end
            end
            S_HBLANK: begin
                if (w_vs_rise) begin
                    w_close_frame = 1'b1;
                    w_state_nxt   = S_VBLANK;
                end else if (w_hs_fall) begin
                    // The first pixel of a line can arrive with the hs fall
                    w_start_line = 1'b1;
                    w_count      = w_pix;
                    w_state_nxt  = S_LINE;
                end
            end
            S_LINE: begin
                if (w_vs_rise) begin
                    w_close_line  = 1'b1;
                    w_close_frame = 1'b1;
                    w_set_sync    = ~w_hs_rise;
                    w_state_nxt   = S_VBLANK;
                end else if (w_hs_rise) begin
                    w_close_line = 1'b1;
                    w_state_nxt  = S_HBLANK;
                end else begin
                    w_count = w_pix;
                end
            end
            default: begin
                w_state_nxt = S_SYNC;
            end
        endcase
    end

    // Saturating pixel and line counters
    logic [CNT_WIDTH-1:0] r_pix_cnt;
    logic [CNT_WIDTH-1:0] r_line_cnt;
    logic [CNT_WIDTH-1:0] w_line_inc;
    logic [CNT_WIDTH-1:0] w_frame_lines;

    assign w_line_inc    = (r_line_cnt == C_CNT_MAX) ? r_line_cnt : r_line_cnt + 1'b1;
    assign w_frame_lines = w_close_line ? w_line_inc : r_line_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
        end else begin
            if (w_start_line) begin
                r_pix_cnt <= {{(CNT_WIDTH-1){1'b0}}, w_count};
            end else if (w_count && (r_pix_cnt != C_CNT_MAX)) begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
            end

            if (w_start_frame) begin
                r_line_cnt <= '0;
            end else if (w_close_line) begin
                r_line_cnt <= w_line_inc;
            end
        end
    end

    // Results and sticky errors
    logic                 w_set_width;
    logic                 w_set_height;
    logic [CNT_WIDTH-1:0] r_line_width;
    logic [CNT_WIDTH-1:0] r_frame_height;
    logic [15:0]          r_frame_cnt;
    logic                 r_line_done;
    logic                 r_frame_done;
    logic                 r_err_width;
    logic                 r_err_height;
    logic                 r_err_sync;

    assign w_set_width  = w_close_line  && (r_exp_w != '0) && (r_pix_cnt != r_exp_w);
    assign w_set_height = w_close_frame && (r_exp_h != '0) && (w_frame_lines != r_exp_h);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_width   <= '0;
            r_frame_height <= '0;
            r_frame_cnt    <= '0;
            r_line_done    <= 1'b0;
            r_frame_done   <= 1'b0;
            r_err_width    <= 1'b0;
            r_err_height   <= 1'b0;
            r_err_sync     <= 1'b0;
        end else begin
            r_line_done  <= w_close_line;
            r_frame_done <= w_close_frame;
            if (w_close_line) begin
                r_line_width <= r_pix_cnt;
            end
            if (w_close_frame) begin
                r_frame_height <= w_frame_lines;
            end
            // A clear and a frame close in the same cycle leave a count of one
            if (r_clr) begin
                r_frame_cnt <= w_close_frame ? 16'd1 : 16'd0;
            end else if (w_close_frame) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            r_err_width  <= (r_err_width  & ~r_clr) | w_set_width;
            r_err_height <= (r_err_height & ~r_clr) | w_set_height;
            r_err_sync   <= (r_err_sync   & ~r_clr) | w_set_sync;
        end
    end

    assign line_width   = r_line_width;
    assign frame_height = r_frame_height;
    assign frame_cnt    = r_frame_cnt;
    assign line_done    = r_line_done;
    assign frame_done   = r_frame_done;
    assign err_width    = r_err_width;
    assign err_height   = r_err_height;
    assign err_sync     = r_err_sync;

`ifdef VIDEO_METER_SUM_EN
    logic [31:0] r_acc;
    logic [31:0] r_frame_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_frame_sum <= '0;
        end else begin
            if (w_start_frame) begin
                r_acc <= '0;
            end else if (w_count) begin
                r_acc <= r_acc + 32'(r_di);
            end
            if (w_close_frame) begin
                r_frame_sum <= r_acc;
            end
        end
    end

    assign frame_sum = r_frame_sum;
`else
    logic w_unused_di;
    assign w_unused_di = ^r_di;
`endif

endmodule
`default_nettype wire
